// File: rtl/mem_check_monitor.sv
// Memory write monitor: compares CPU data-memory writes against a table of
// expected (address, value) pairs and reports pass/fail for a bounded run.
module mem_check_monitor #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT    = 1000,
    parameter int MODE       = 0,
    localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [NUM_CHECKS-1:0] match_mask,
    output logic [IDX_W-1:0]      first_fail_idx,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     exp_addr_r [NUM_CHECKS];
    logic [DATA_W-1:0]     exp_data_r [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] valid_r;
    logic [NUM_CHECKS-1:0] match_r;
    logic [NUM_CHECKS-1:0] match_next_s;
    logic [NUM_CHECKS-1:0] pending_s;
    logic                  all_ok_s;
    logic                  at_limit_s;
    logic [IDX_W-1:0]      low_idx_s;
    logic [IDX_W-1:0]      ffi_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  done_r;
    logic                  pass_r;
    logic                  fail_r;

    // Match vector including the current cycle's write; every entry sharing the address is updated.
    always_comb begin
        match_next_s = match_r;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (mem_we && valid_r[i] && (exp_addr_r[i] == mem_addr)) begin
                match_next_s[i] = (mem_wdata == exp_data_r[i]);
            end else begin
                match_next_s[i] = match_r[i];
            end
        end
    end

    // Run verdict inputs: outstanding entries, lowest outstanding index, last-cycle flag.
    always_comb begin
        pending_s  = valid_r & ~match_next_s;
        all_ok_s   = (pending_s == {NUM_CHECKS{1'b0}});
        at_limit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
        low_idx_s  = {IDX_W{1'b0}};
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (pending_s[i]) begin
                low_idx_s = IDX_W'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Expectation table; contents survive reset, only the valid bits are cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (!reset && (state_r == ST_IDLE) && cfg_we && (cfg_idx == IDX_W'(i))) begin
                exp_addr_r[i] <= cfg_addr;
                exp_data_r[i] <= cfg_data;
            end
        end
    end

    // Run control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            valid_r <= {NUM_CHECKS{1'b0}};
            match_r <= {NUM_CHECKS{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ffi_r   <= {IDX_W{1'b0}};
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                            valid_r[i] <= 1'b1;
                        end
                    end
                    if (start) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {CNT_W{1'b0}};
                        match_r <= {NUM_CHECKS{1'b0}};
                    end
                end
                ST_RUN: begin
                    match_r <= match_next_s;
                    if (cnt_r != CNT_W'(TIMEOUT)) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    // Early pass only in mode 0; both modes decide on the last cycle.
                    if ((MODE == 0) && all_ok_s) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else if (at_limit_s && all_ok_s) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else if (at_limit_s) begin
                        state_r <= ST_FAIL;
                        done_r  <= 1'b1;
                        fail_r  <= 1'b1;
                        ffi_r   <= low_idx_s;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (clear) begin
                        state_r <= ST_IDLE;
                        match_r <= {NUM_CHECKS{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        ffi_r   <= {IDX_W{1'b0}};
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        fail_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    match_r <= {NUM_CHECKS{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    ffi_r   <= {IDX_W{1'b0}};
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                    fail_r  <= 1'b0;
                end
            endcase
        end
    end

    assign done           = done_r;
    assign pass           = pass_r;
    assign fail           = fail_r;
    assign match_mask     = match_r;
    assign first_fail_idx = ffi_r;
    assign cycle_count    = cnt_r;

endmodule

// File: tb/tb_mem_check_monitor.sv
// Scoreboard bench: one MODE 0 and one MODE 1 monitor see identical stimulus;
// a table-driven reference computes each run's verdict before it is issued.
module tb_mem_check_monitor;

    localparam int TO = 100;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [31:0] cfg_addr = 32'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [1:0]  done_v, pass_v, fail_v;
    logic [3:0]  mask_v [2];
    logic [1:0]  ffi_v [2];
    logic [6:0]  cnt_v [2];

    always #5 clk = ~clk;

    mem_check_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .MODE(0)) u_mode0 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
        .match_mask(mask_v[0]), .first_fail_idx(ffi_v[0]), .cycle_count(cnt_v[0]));

    mem_check_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .MODE(1)) u_mode1 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
        .match_mask(mask_v[1]), .first_fail_idx(ffi_v[1]), .cycle_count(cnt_v[1]));

    typedef struct packed {
        logic       p;
        logic       f;
        logic [3:0] mask;
        logic [1:0] ffi;
        logic [6:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] m_addr [NC];
    logic [31:0] m_data [NC];
    logic [3:0]  m_valid = 4'd0;
    logic        w_en   [TO];
    logic [31:0] w_addr [TO];
    logic [31:0] w_data [TO];

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[mode%0d]: got %0h expected %0h", name, inst, act, exp);
        end
    endtask

    // Reference: replay the planned writes against the table and find the verdict cycle.
    function automatic exp_t model(input int mode);
        exp_t       e;
        logic [3:0] m;
        logic       ok;
        logic       decided;
        m = 4'd0;
        e = '0;
        decided = 1'b0;
        for (int t = 0; t < TO; t++) begin
            if (!decided) begin
                if (w_en[t]) begin
                    for (int i = 0; i < NC; i++) begin
                        if (m_valid[i] && m_addr[i] == w_addr[t]) m[i] = (w_data[t] == m_data[i]);
                    end
                end
                ok = ((m_valid & ~m) == 4'd0);
                if ((mode == 0 && ok) || t == TO - 1) begin
                    decided = 1'b1;
                    e.p = ok;
                    e.f = !ok;
                    e.mask = m;
                    e.cnt = 7'(t + 1);
                    e.ffi = 2'd0;
                    if (!ok) begin
                        for (int i = NC - 1; i >= 0; i--) begin
                            if (m_valid[i] && !m[i]) e.ffi = 2'(i);
                        end
                    end
                end
            end
        end
        return e;
    endfunction

    // Monitor: on each rising done, pop that instance's expectation and compare.
    logic [1:0] done_q = 2'b00;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k] && !done_q[k]) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done[mode%0d]: got done=1 expected no pending run", k);
                end else begin
                    if (k == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    chk("pass_flag", k, 32'(pass_v[k]), 32'(mon_e.p));
                    chk("fail_flag", k, 32'(fail_v[k]), 32'(mon_e.f));
                    chk("match_mask", k, 32'(mask_v[k]), 32'(mon_e.mask));
                    chk("first_fail_idx", k, 32'(ffi_v[k]), 32'(mon_e.ffi));
                    chk("cycle_count", k, 32'(cnt_v[k]), 32'(mon_e.cnt));
                end
            end
        end
        done_q = done_v;
    end

    task automatic check_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_done"}, k, 32'(done_v[k]), 32'd0);
            chk({name, "_pf"}, k, 32'({pass_v[k], fail_v[k]}), 32'd0);
            chk({name, "_mask"}, k, 32'(mask_v[k]), 32'd0);
            chk({name, "_ffi"}, k, 32'(ffi_v[k]), 32'd0);
            chk({name, "_cnt"}, k, 32'(cnt_v[k]), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_valid = 4'd0;
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
        @(posedge clk); #1 cfg_we = 1'b0;
        m_addr[idx] = a; m_data[idx] = d; m_valid[idx] = 1'b1;
    endtask

    task automatic no_writes();
        for (int t = 0; t < TO; t++) begin
            w_en[t] = 1'b0; w_addr[t] = 32'd0; w_data[t] = 32'd0;
        end
    endtask

    task automatic set_write(input int t, input logic [31:0] a, input logic [31:0] d);
        w_en[t] = 1'b1; w_addr[t] = a; w_data[t] = d;
    endtask

    task automatic do_run(input int abort_at, input logic noise);
        exp_t e0, e1;
        logic aborted;
        aborted = 1'b0;
        e0 = model(0);
        e1 = model(1);
        if (abort_at < 0) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int t = 0; t < TO && !aborted; t++) begin
            mem_we = w_en[t]; mem_addr = w_addr[t]; mem_wdata = w_data[t];
            if (noise) begin
                cfg_we = ($urandom_range(0, 9) == 0);
                cfg_idx = 2'($urandom);
                cfg_addr = 32'd84;
                cfg_data = $urandom;
                start = ($urandom_range(0, 7) == 0);
            end
            if (t == abort_at) reset = 1'b1;
            @(posedge clk); #1;
            cfg_we = 1'b0; start = 1'b0; mem_we = 1'b0;
            if (t == abort_at) begin
                reset = 1'b0;
                m_valid = 4'd0;
                aborted = 1'b1;
                @(negedge clk);
                check_zero("abort");
            end
        end
        if (!aborted) begin
            @(negedge clk);
            chk("done_at_end", 0, 32'(done_v[0]), 32'd1);
            chk("done_at_end", 1, 32'(done_v[1]), 32'd1);
            chk("mask_held", 0, 32'(mask_v[0]), 32'(e0.mask));
            chk("mask_held", 1, 32'(mask_v[1]), 32'(e1.mask));
            chk("cnt_held", 0, 32'(cnt_v[0]), 32'(e0.cnt));
            @(posedge clk); #1;
            clear = 1'b1;
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1 clear = 1'b0; start = 1'b0;
            @(negedge clk);
            check_zero("after_clear");
            @(posedge clk); #1;
        end
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;

        no_writes();
        do_run(-1, 1'b0);

        cfg(0, 32'd84, 32'd7);
        no_writes(); set_write(20, 32'd84, 32'd7);
        do_run(-1, 1'b0);

        no_writes(); set_write(10, 32'd84, 32'd7); set_write(50, 32'd84, 32'd3);
        do_run(-1, 1'b0);

        no_writes(); set_write(TO - 1, 32'd84, 32'd7);
        do_run(-1, 1'b0);

        cfg(1, 32'd88, 32'd11);
        no_writes(); set_write(5, 32'd84, 32'd7);
        do_run(-1, 1'b0);

        no_writes(); set_write(12, 32'd88, 32'd11);
        do_run(30, 1'b0);
        no_writes();
        do_run(-1, 1'b0);
        cfg(0, 32'd84, 32'd7);
        no_writes(); set_write(3, 32'd84, 32'd7);
        do_run(-1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            for (int c = $urandom_range(0, 3); c > 0; c--) begin
                cfg($urandom_range(0, NC - 1), 32'd84 + 32'($urandom_range(0, 3)) * 32'd4,
                    32'($urandom_range(0, 15)));
            end
            no_writes();
            for (int t = 0; t < TO; t++) begin
                if ($urandom_range(0, 5) == 0) begin
                    int j;
                    j = $urandom_range(0, NC - 1);
                    if ($urandom_range(0, 1) == 0)
                        set_write(t, m_addr[j], m_data[j]);
                    else
                        set_write(t, ($urandom_range(0, 7) == 0) ? 32'd200 : 32'd84 + 32'($urandom_range(0, 3)) * 32'd4,
                                  32'($urandom_range(0, 15)));
                end
            end
            do_run(-1, 1'b1);
        end

        chk("runs_unfinished", 0, 32'(q0.size()), 32'd0);
        chk("runs_unfinished", 1, 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            m_addr[i] = 32'd0;
            m_data[i] = 32'd0;
        end
    end

endmodule
